// File: rtl/seq_sched_pkg.sv
// Shared types and helpers for the round-robin serial pattern detector scheduler.
package seq_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        STREAM,
        REPORT
    } state_e;

    // Pattern loaded at reset, resized to the configured pattern width where used.
    localparam logic [3:0] DEFAULT_PAT = 4'b1011;

    // Ceiling log2 with a floor of 1 so derived vectors never collapse to zero width.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = 1; v < n; v = v * 2) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/seq_pat_match.sv
// Serial pattern matcher: LSB-first history shift register, fill tracking,
// programmable compare and a registered one-cycle match flag.
module seq_pat_match
    import seq_sched_pkg::*;
#(
    parameter int PAT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             shift_en_i,
    input  logic             bit_i,
    input  logic [PAT_W-1:0] pattern_i,
    output logic             hit_o,
    output logic             flag_o
);

    localparam int FILL_W = clog2(PAT_W + 1);

    logic [PAT_W-1:0]  shift_q;
    logic [PAT_W-1:0]  shift_d;
    logic [FILL_W-1:0] fill_q;
    logic [FILL_W-1:0] fill_d;
    logic              flag_q;

    // Look ahead at the history as it will be after this bit, so a match is known in the accepting cycle.
    always_comb begin
        shift_d = PAT_W'({shift_q, bit_i});
        fill_d  = (fill_q == FILL_W'(PAT_W)) ? fill_q : fill_q + 1'b1;
        hit_o   = shift_en_i && (fill_d == FILL_W'(PAT_W)) && (shift_d == pattern_i);
    end

    // History, fill and flag registers; clearing wipes history so frames never match across each other.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q <= '0;
            fill_q  <= '0;
            flag_q  <= 1'b0;
        end else if (clr_i) begin
            shift_q <= '0;
            fill_q  <= '0;
            flag_q  <= 1'b0;
        end else begin
            if (shift_en_i) begin
                shift_q <= shift_d;
                fill_q  <= fill_d;
            end
            flag_q <= hit_o;
        end
    end

    assign flag_o = flag_q;

endmodule

// File: rtl/seq_detect_sched.sv
// Round-robin scheduler sharing one serial pattern matcher between N_CH requesters.
// Optional idle timeout per frame is compiled in with SEQ_SCHED_TIMEOUT_EN.
module seq_detect_sched
    import seq_sched_pkg::*;
#(
    parameter int N_CH      = 4,
    parameter int PAT_W     = 4,
    parameter int FRAME_LEN = 16,
    parameter int CNT_W     = 8,
    parameter int TIMEOUT   = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_we,
    input  logic [PAT_W-1:0]         cfg_pattern,
    input  logic [N_CH-1:0]          req,
    input  logic [N_CH-1:0]          din,
    input  logic [N_CH-1:0]          din_vld,
    output logic [N_CH-1:0]          grant,
    output logic                     flag,
    output logic                     done,
    output logic [clog2(N_CH)-1:0]   done_ch,
    output logic [CNT_W-1:0]         match_cnt,
    output logic                     done_abort
);

    localparam int CH_W  = clog2(N_CH);
    localparam int BIT_W = clog2(FRAME_LEN + 1);
    localparam logic [N_CH-1:0] ONE_HOT0 = N_CH'(1);

    state_e            state_q;
    logic [CH_W-1:0]   cur_q;
    logic [CH_W-1:0]   rr_q;
    logic [PAT_W-1:0]  shadow_q;
    logic [PAT_W-1:0]  pat_q;
    logic [BIT_W-1:0]  bit_cnt_q;
    logic [CNT_W-1:0]  frame_cnt_q;
    logic [N_CH-1:0]   grant_q;
    logic              done_q;
    logic [CH_W-1:0]   done_ch_q;
    logic [CNT_W-1:0]  match_cnt_q;

    logic [CH_W-1:0]   pick_d;
    logic [CH_W-1:0]   idx_c;
    logic              found;
    int                idx;
    logic [CH_W-1:0]   rr_d;
    logic [CNT_W-1:0]  cnt_d;
    logic              cur_bit;
    logic              cur_vld;
    logic              accept;
    logic              last_bit;
    logic              frame_end;
    logic              hit;
    logic              pm_flag;

`ifdef SEQ_SCHED_TIMEOUT_EN
    localparam int TO_W = clog2(TIMEOUT + 1);
    logic [TO_W-1:0]   idle_q;
    logic              idle_expire;
    logic              abort_q;
`else
    logic              unused_timeout;
    assign unused_timeout = ^TIMEOUT;
`endif

    // Search requesters starting at the round-robin pointer and wrapping, first set bit wins.
    always_comb begin
        pick_d = rr_q;
        found  = 1'b0;
        idx    = 0;
        idx_c  = '0;
        for (int i = 0; i < N_CH; i++) begin
            idx = int'(rr_q) + i;
            if (idx >= N_CH) begin
                idx = idx - N_CH;
            end
            idx_c = CH_W'(idx);
            if (!found && req[idx_c]) begin
                pick_d = idx_c;
                found  = 1'b1;
            end
        end
    end

    // Per-cycle frame decode: accepted bit, saturating count including this bit, and frame end.
    always_comb begin
        cur_bit   = din[cur_q];
        cur_vld   = din_vld[cur_q];
        accept    = (state_q == STREAM) && cur_vld;
        last_bit  = accept && (bit_cnt_q == BIT_W'(FRAME_LEN - 1));
        cnt_d     = (hit && (frame_cnt_q != '1)) ? frame_cnt_q + 1'b1 : frame_cnt_q;
        rr_d      = (cur_q == CH_W'(N_CH - 1)) ? '0 : cur_q + 1'b1;
`ifdef SEQ_SCHED_TIMEOUT_EN
        idle_expire = (state_q == STREAM) && !cur_vld && (idle_q == TO_W'(TIMEOUT - 1));
        frame_end   = last_bit || idle_expire;
`else
        frame_end   = last_bit;
`endif
    end

    // Shadow pattern takes every write; the matcher only sees it once a new frame loads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q <= PAT_W'(DEFAULT_PAT);
        end else if (cfg_we) begin
            shadow_q <= cfg_pattern;
        end
    end

    // Scheduler FSM with registered grant and report outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cur_q       <= '0;
            rr_q        <= '0;
            pat_q       <= PAT_W'(DEFAULT_PAT);
            bit_cnt_q   <= '0;
            frame_cnt_q <= '0;
            grant_q     <= '0;
            done_q      <= 1'b0;
            done_ch_q   <= '0;
            match_cnt_q <= '0;
`ifdef SEQ_SCHED_TIMEOUT_EN
            idle_q      <= '0;
            abort_q     <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (|req) begin
                        cur_q   <= pick_d;
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    bit_cnt_q   <= '0;
                    frame_cnt_q <= '0;
                    pat_q       <= shadow_q;
                    grant_q     <= ONE_HOT0 << cur_q;
`ifdef SEQ_SCHED_TIMEOUT_EN
                    idle_q      <= '0;
`endif
                    state_q     <= STREAM;
                end
                STREAM: begin
                    if (accept) begin
                        bit_cnt_q   <= bit_cnt_q + 1'b1;
                        frame_cnt_q <= cnt_d;
                    end
`ifdef SEQ_SCHED_TIMEOUT_EN
                    idle_q <= accept ? '0 : idle_q + 1'b1;
`endif
                    if (frame_end) begin
                        grant_q     <= '0;
                        done_q      <= 1'b1;
                        done_ch_q   <= cur_q;
                        match_cnt_q <= cnt_d;
`ifdef SEQ_SCHED_TIMEOUT_EN
                        abort_q     <= !last_bit;
`endif
                        state_q     <= REPORT;
                    end
                end
                REPORT: begin
                    rr_q    <= rr_d;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    seq_pat_match #(
        .PAT_W (PAT_W)
    ) u_match (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (state_q == LOAD),
        .shift_en_i (accept),
        .bit_i      (cur_bit),
        .pattern_i  (pat_q),
        .hit_o      (hit),
        .flag_o     (pm_flag)
    );

    assign grant     = grant_q;
    assign flag      = pm_flag;
    assign done      = done_q;
    assign done_ch   = done_ch_q;
    assign match_cnt = match_cnt_q;
`ifdef SEQ_SCHED_TIMEOUT_EN
    assign done_abort = abort_q;
`else
    assign done_abort = 1'b0;
`endif

endmodule
